// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory port between the instruction-fetch
// (IF) and load/store (LS) requesters. It keeps one outstanding transaction and
// returns the response to its owner. A bounded LS-priority streak keeps IF from
// being starved, and a jump flush quietly drops an in-flight IF response.
module mem_bus_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int LS_STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    input  logic                if_flush,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                ls_req_valid,
    input  logic                ls_req_wen,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_req_ready,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,
    output logic                mem_req_valid,
    output logic                mem_req_wen,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(LS_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(LS_STREAK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_ls_q, owner_ls_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                drop_q, drop_d;
    logic                req_wen_q, req_wen_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [MASK_W-1:0]   req_wmask_q, req_wmask_d;
    logic                if_resp_valid_q, if_resp_valid_d;
    logic [DATA_W-1:0]   if_resp_data_q, if_resp_data_d;
    logic                ls_resp_valid_q, ls_resp_valid_d;
    logic [DATA_W-1:0]   ls_resp_data_q, ls_resp_data_d;

    logic if_elig;
    logic grant_if;
    logic grant_ls;
    logic resp_fire;

    // Arbitration: LS normally wins a contest, IF wins once the streak saturates.
    // Grants are gated by rst so the ready outputs read 0 throughout reset.
    always_comb begin
        if_elig   = if_req_valid & ~if_flush;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        resp_fire = (state_q == ST_WAIT) & mem_resp_valid;
        if ((state_q == ST_IDLE) && !rst) begin
            grant_if = if_elig & (~ls_req_valid | (streak_q == STREAK_SAT));
            grant_ls = ls_req_valid & ~grant_if;
        end
    end

    // State register: the only place the FSM state is stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept, hand to memory, then wait for the single response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_if || grant_ls) state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)        state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid)       state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: readies only in IDLE, request valid only while presenting.
    always_comb begin
        if_req_ready  = grant_if;
        ls_req_ready  = grant_ls;
        mem_req_valid = (state_q == ST_REQ);
        busy          = (state_q != ST_IDLE);
    end

    // Request latch, streak counter, flush-drop flag and response capture.
    always_comb begin
        owner_ls_d      = owner_ls_q;
        req_wen_d       = req_wen_q;
        req_addr_d      = req_addr_q;
        req_wdata_d     = req_wdata_q;
        req_wmask_d     = req_wmask_q;
        streak_d        = streak_q;
        drop_d          = drop_q;
        if_resp_valid_d = 1'b0;
        if_resp_data_d  = if_resp_data_q;
        ls_resp_valid_d = 1'b0;
        ls_resp_data_d  = ls_resp_data_q;

        if (grant_if) begin
            owner_ls_d  = 1'b0;
            req_wen_d   = 1'b0;
            req_addr_d  = if_req_addr;
            req_wdata_d = '0;
            req_wmask_d = '0;
            streak_d    = '0;
        end else if (grant_ls) begin
            owner_ls_d  = 1'b1;
            req_wen_d   = ls_req_wen;
            req_addr_d  = ls_req_addr;
            req_wdata_d = ls_req_wdata;
            req_wmask_d = ls_req_wmask;
            if (if_elig && (streak_q != STREAK_SAT)) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end

        // A flush in the response cycle still counts, so it is checked directly.
        if (resp_fire) begin
            if (owner_ls_q) begin
                ls_resp_valid_d = 1'b1;
                ls_resp_data_d  = req_wen_q ? '0 : mem_resp_data;
            end else if (!drop_q && !if_flush) begin
                if_resp_valid_d = 1'b1;
                if_resp_data_d  = mem_resp_data;
            end
        end

        if (state_d == ST_IDLE) begin
            drop_d = 1'b0;
        end else if ((state_q != ST_IDLE) && !owner_ls_q && if_flush) begin
            drop_d = 1'b1;
        end
    end

    // Datapath and control registers; everything visible clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_ls_q      <= 1'b0;
            streak_q        <= '0;
            drop_q          <= 1'b0;
            req_wen_q       <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_wmask_q     <= '0;
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= '0;
            ls_resp_valid_q <= 1'b0;
            ls_resp_data_q  <= '0;
        end else begin
            owner_ls_q      <= owner_ls_d;
            streak_q        <= streak_d;
            drop_q          <= drop_d;
            req_wen_q       <= req_wen_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            req_wmask_q     <= req_wmask_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            ls_resp_data_q  <= ls_resp_data_d;
        end
    end

    assign mem_req_wen   = req_wen_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;
    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_data  = if_resp_data_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign ls_resp_data  = ls_resp_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of requesters and memory.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int MAXS   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_flush;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              ls_req_valid;
    logic              ls_req_wen;
    logic [ADDR_W-1:0] ls_req_addr;
    logic [DATA_W-1:0] ls_req_wdata;
    logic [MASK_W-1:0] ls_req_wmask;
    logic              ls_req_ready;
    logic              ls_resp_valid;
    logic [DATA_W-1:0] ls_resp_data;
    logic              mem_req_valid;
    logic              mem_req_wen;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [logic [31:0]];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LS_STREAK_MAX(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        if_req_valid   = 1'b0;
        if_req_addr    = '0;
        if_flush       = 1'b0;
        ls_req_valid   = 1'b0;
        ls_req_wen     = 1'b0;
        ls_req_addr    = '0;
        ls_req_wdata   = '0;
        ls_req_wmask   = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        zero_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            if_req_valid = 1'($urandom); if_req_addr = $urandom; if_flush = 1'($urandom);
            ls_req_valid = 1'($urandom); ls_req_wen = 1'($urandom); ls_req_addr = $urandom;
            ls_req_wdata = $urandom; ls_req_wmask = 4'($urandom);
            mem_req_ready = 1'($urandom); mem_resp_valid = 1'($urandom); mem_resp_data = $urandom;
            smp();
            checks++;
            if ({if_req_ready, if_resp_valid, if_resp_data, ls_req_ready, ls_resp_valid, ls_resp_data,
                 mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask, busy} !== '0)
                begin errors++; $display("FAIL reset_outputs cycle %0d: rdy=%b%b busy=%b mval=%b addr=%h ifd=%h lsd=%h, all must be 0",
                    i, if_req_ready, ls_req_ready, busy, mem_req_valid, mem_req_addr, if_resp_data, ls_resp_data); end
        end
        tick();
        rst = 1'b0; zero_inputs();
        if_req_valid = 1'b1; if_req_addr = 32'h8000_0000;
        smp();
        checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b10) begin errors++;
            $display("FAIL reset_first_accept: ready if/ls=%b%b, want 10", if_req_ready, ls_req_ready); end
        tick();
        if_req_valid = 1'b0; if_req_addr = $urandom; mem_req_ready = 1'b1;
        smp();
        checks++;
        if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask} !== {1'b1, 1'b0, 32'h8000_0000, 4'h0}) begin errors++;
            $display("FAIL reset_first_memreq: v=%b wen=%b addr=%h mask=%h, want 1 0 80000000 0",
                mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask); end
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0413;
        smp();
        checks++;
        if ({if_resp_valid, busy} !== 2'b01) begin errors++;
            $display("FAIL reset_first_wait: if_resp_valid=%b busy=%b, want 0 1", if_resp_valid, busy); end
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        smp();
        checks++;
        if ({if_resp_valid, if_resp_data, busy} !== {1'b1, 32'h0000_0413, 1'b0}) begin errors++;
            $display("FAIL reset_first_resp: v=%b data=%h busy=%b, want 1 00000413 0", if_resp_valid, if_resp_data, busy); end
        tick();
        smp();
        checks++;
        if ({if_resp_valid, if_resp_data} !== {1'b0, 32'h0000_0413}) begin errors++;
            $display("FAIL reset_first_pulse_end: v=%b data=%h, want 0 00000413", if_resp_valid, if_resp_data); end
    endtask

    task automatic test_store();
        tick();
        ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_req_addr = 32'h8000_1000;
        ls_req_wdata = 32'hDEAD_BEEF; ls_req_wmask = 4'hF;
        smp();
        checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b01) begin errors++;
            $display("FAIL store_accept: ready if/ls=%b%b, want 01", if_req_ready, ls_req_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            ls_req_valid = 1'b0; ls_req_wen = 1'($urandom); ls_req_addr = $urandom; ls_req_wdata = $urandom;
            mem_req_ready = (i == 4);
            smp();
            checks++;
            if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask} !==
                {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin errors++;
                $display("FAIL store_hold cycle %0d: v=%b wen=%b addr=%h wd=%h m=%h, want 1 1 80001000 deadbeef f",
                    i, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask); end
        end
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
        smp();
        checks++;
        if ({mem_req_valid, busy, ls_resp_valid} !== 3'b010) begin errors++;
            $display("FAIL store_wait: mval=%b busy=%b lsv=%b, want 0 1 0", mem_req_valid, busy, ls_resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
        smp();
        checks++;
        if ({ls_resp_valid, ls_resp_data, if_resp_valid} !== {1'b1, 32'h0, 1'b0}) begin errors++;
            $display("FAIL store_resp: lsv=%b lsd=%h ifv=%b, want 1 00000000 0", ls_resp_valid, ls_resp_data, if_resp_valid); end
        tick();
        smp();
        checks++;
        if (ls_resp_valid !== 1'b0) begin errors++;
            $display("FAIL store_pulse_width: lsv=%b, want 0", ls_resp_valid); end
    endtask

    task automatic test_starvation();
        int grants, ph, cyc;
        bit e_if, e_ls;
        grants = 0; ph = 0; cyc = 0;
        do_reset();
        while (cyc < 200 && !(grants >= 12 && ph == 0)) begin
            tick();
            if_req_valid = (grants < 12); if_req_addr = 32'h8000_0100;
            ls_req_valid = (grants < 12); ls_req_wen = 1'b0; ls_req_addr = 32'h8000_2000;
            mem_req_ready = (ph == 1); mem_resp_valid = (ph == 2); mem_resp_data = $urandom;
            smp();
            e_if = (ph == 0) && (grants < 12) && (grants % 5 == 4);
            e_ls = (ph == 0) && (grants < 12) && (grants % 5 != 4);
            checks++;
            if ({if_req_ready, ls_req_ready} !== {e_if, e_ls}) begin errors++;
                $display("FAIL starvation_grant %0d: ready if/ls=%b%b, want %b%b", grants, if_req_ready, ls_req_ready, e_if, e_ls); end
            if (if_req_ready || ls_req_ready) begin grants++; ph = 1; end
            else if (ph == 1) ph = 2;
            else if (ph == 2) ph = 0;
            cyc++;
        end
        checks++;
        if (grants != 12) begin errors++;
            $display("FAIL starvation_budget: grants=%0d, want 12 within 200 cycles", grants); end
    endtask

    task automatic test_flush_inflight();
        // Flush while waiting, response arrives later.
        tick();
        zero_inputs(); if_req_valid = 1'b1; if_req_addr = 32'h8000_0010;
        smp();
        checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b10) begin errors++;
            $display("FAIL flush_accept: ready if/ls=%b%b, want 10", if_req_ready, ls_req_ready); end
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1; smp();
        tick(); mem_req_ready = 1'b0; if_flush = 1'b1; smp();
        tick(); if_flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA_5555; smp();
        tick();
        mem_resp_valid = 1'b0;
        ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 32'h8000_1000; ls_req_wdata = $urandom; ls_req_wmask = 4'h0;
        smp();
        checks++;
        if ({if_resp_valid, busy, ls_req_ready} !== 3'b001) begin errors++;
            $display("FAIL flush_dropped: ifv=%b busy=%b ls_rdy=%b, want 0 0 1", if_resp_valid, busy, ls_req_ready); end
        tick(); ls_req_valid = 1'b0; mem_req_ready = 1'b1; smp();
        checks++;
        if ({mem_req_valid, mem_req_wen, mem_req_addr} !== {1'b1, 1'b0, 32'h8000_1000}) begin errors++;
            $display("FAIL flush_ls_memreq: v=%b wen=%b addr=%h, want 1 0 80001000", mem_req_valid, mem_req_wen, mem_req_addr); end
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D; smp();
        tick(); mem_resp_valid = 1'b0; smp();
        checks++;
        if ({ls_resp_valid, ls_resp_data, if_resp_valid} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin errors++;
            $display("FAIL flush_ls_resp: lsv=%b lsd=%h ifv=%b, want 1 cafef00d 0", ls_resp_valid, ls_resp_data, if_resp_valid); end
        // Flush in the very cycle the IF response arrives.
        tick(); if_req_valid = 1'b1; if_req_addr = 32'h8000_0014; smp();
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1; smp();
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; if_flush = 1'b1; mem_resp_data = 32'h5555_AAAA; smp();
        tick(); mem_resp_valid = 1'b0; if_flush = 1'b0; smp();
        checks++;
        if ({if_resp_valid, busy} !== 2'b00) begin errors++;
            $display("FAIL flush_same_cycle: ifv=%b busy=%b, want 0 0", if_resp_valid, busy); end
    endtask

    task automatic test_flush_idle();
        tick();
        zero_inputs(); if_req_valid = 1'b1; if_req_addr = 32'h8000_0020; if_flush = 1'b1;
        smp();
        checks++;
        if ({if_req_ready, ls_req_ready, busy} !== 3'b000) begin errors++;
            $display("FAIL flush_idle_block: if_rdy=%b ls_rdy=%b busy=%b, want 0 0 0", if_req_ready, ls_req_ready, busy); end
        tick(); if_flush = 1'b0; smp();
        checks++;
        if (if_req_ready !== 1'b1) begin errors++;
            $display("FAIL flush_idle_accept: if_rdy=%b, want 1", if_req_ready); end
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1; smp();
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0020}) begin errors++;
            $display("FAIL flush_idle_memreq: v=%b addr=%h, want 1 80000020", mem_req_valid, mem_req_addr); end
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0073; smp();
        tick(); mem_resp_valid = 1'b0; smp();
        checks++;
        if ({if_resp_valid, if_resp_data} !== {1'b1, 32'h0010_0073}) begin errors++;
            $display("FAIL flush_idle_resp: v=%b data=%h, want 1 00100073", if_resp_valid, if_resp_data); end
    endtask

    task automatic test_reset_mid();
        tick(); zero_inputs(); if_req_valid = 1'b1; if_req_addr = 32'h8000_0030; smp();
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1; smp();
        tick(); mem_req_ready = 1'b0; rst = 1'b1; smp();
        tick(); rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777; smp();
        checks++;
        if ({busy, mem_req_valid} !== 2'b00) begin errors++;
            $display("FAIL reset_mid_idle: busy=%b mval=%b, want 0 0", busy, mem_req_valid); end
        tick(); mem_resp_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h8000_0040; smp();
        checks++;
        if ({if_resp_valid, ls_resp_valid, busy, if_req_ready} !== 4'b0001) begin errors++;
            $display("FAIL reset_mid_late_resp: ifv=%b lsv=%b busy=%b if_rdy=%b, want 0 0 0 1",
                if_resp_valid, ls_resp_valid, busy, if_req_ready); end
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1; smp();
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0040}) begin errors++;
            $display("FAIL reset_mid_memreq: v=%b addr=%h, want 1 80000040", mem_req_valid, mem_req_addr); end
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_1111; smp();
        tick(); mem_resp_valid = 1'b0; smp();
        checks++;
        if ({if_resp_valid, if_resp_data} !== {1'b1, 32'h1111_1111}) begin errors++;
            $display("FAIL reset_mid_next_resp: v=%b data=%h, want 1 11111111", if_resp_valid, if_resp_data); end
    endtask

    task automatic test_random();
        int streak, phase, cnt;
        bit open, own_ls, drop, ifp, lsp, lsw, c_w, e_if, e_ls, exp_ifv, exp_lsv, resp_now;
        logic [31:0] ifa, lsa, lswd, c_addr, c_wd, exp_ifd, exp_lsd, rv, nv;
        logic [3:0] lsm, c_m;
        streak = 0; phase = 0; cnt = 0;
        open = 0; own_ls = 0; drop = 0; ifp = 0; lsp = 0; lsw = 0; c_w = 0;
        exp_ifv = 0; exp_lsv = 0; exp_ifd = '0; exp_lsd = '0; rv = '0;
        ifa = '0; lsa = '0; lswd = '0; lsm = '0; c_addr = '0; c_wd = '0; c_m = '0;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            tick();
            if (!ifp && $urandom_range(0, 2) == 0) begin
                ifp = 1; ifa = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 4;
            end
            if (!lsp && $urandom_range(0, 1) == 0) begin
                lsp = 1; lsw = 1'($urandom); lsa = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 4;
                lswd = $urandom; lsm = 4'($urandom_range(1, 15));
            end
            if_req_valid = ifp; if_req_addr = ifp ? ifa : $urandom;
            if_flush = ($urandom_range(0, 7) == 0);
            ls_req_valid = lsp; ls_req_wen = lsp ? lsw : 1'($urandom);
            ls_req_addr = lsp ? lsa : $urandom; ls_req_wdata = lsp ? lswd : $urandom;
            ls_req_wmask = lsp ? lsm : 4'($urandom);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = $urandom; resp_now = 0;
            if (phase == 1) mem_req_ready = 1'($urandom);
            else if (phase == 2) begin
                if (cnt == 0) begin
                    resp_now = 1; mem_resp_valid = 1'b1; rv = rd(c_addr);
                    if (!c_w) mem_resp_data = rv;
                end else cnt--;
            end else if ($urandom_range(0, 7) == 0) mem_resp_valid = 1'b1;
            smp();
            e_if = !open && ifp && !if_flush && (!lsp || streak == MAXS);
            e_ls = !open && lsp && !e_if;
            checks++;
            if ({if_req_ready, ls_req_ready} !== {e_if, e_ls}) begin errors++;
                $display("FAIL rand_grant cyc %0d: ready if/ls=%b%b, want %b%b (streak %0d)", cyc, if_req_ready, ls_req_ready, e_if, e_ls, streak); end
            checks++;
            if ({if_resp_valid, ls_resp_valid} !== {exp_ifv, exp_lsv}) begin errors++;
                $display("FAIL rand_resp_valid cyc %0d: if/ls=%b%b, want %b%b", cyc, if_resp_valid, ls_resp_valid, exp_ifv, exp_lsv); end
            if (exp_ifv) begin
                checks++;
                if (if_resp_data !== exp_ifd) begin errors++;
                    $display("FAIL rand_if_data cyc %0d: got %h, want %h", cyc, if_resp_data, exp_ifd); end
            end
            if (exp_lsv) begin
                checks++;
                if (ls_resp_data !== exp_lsd) begin errors++;
                    $display("FAIL rand_ls_data cyc %0d: got %h, want %h", cyc, ls_resp_data, exp_lsd); end
            end
            checks++;
            if ({mem_req_valid, busy} !== {phase == 1, open}) begin errors++;
                $display("FAIL rand_state cyc %0d: mval=%b busy=%b, want %b %b", cyc, mem_req_valid, busy, phase == 1, open); end
            if (phase == 1) begin
                checks++;
                if ({mem_req_wen, mem_req_addr, mem_req_wmask} !== {c_w, c_addr, c_m} ||
                    (own_ls && mem_req_wdata !== c_wd)) begin errors++;
                    $display("FAIL rand_memreq cyc %0d: wen=%b addr=%h wd=%h m=%h, want %b %h %h %h",
                        cyc, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask, c_w, c_addr, c_wd, c_m); end
            end
            exp_ifv = 0; exp_lsv = 0;
            if (open && !own_ls && if_flush) drop = 1;
            if (phase == 1 && mem_req_ready) begin
                phase = 2; cnt = $urandom_range(0, 3);
            end else if (resp_now) begin
                phase = 0; open = 0;
                if (own_ls) begin
                    exp_lsv = 1;
                    if (c_w) begin
                        nv = rv;
                        for (int b = 0; b < 4; b++) if (c_m[b]) nv[8*b +: 8] = c_wd[8*b +: 8];
                        mem_m[c_addr] = nv; exp_lsd = '0;
                    end else exp_lsd = rv;
                end else if (!drop) begin
                    exp_ifv = 1; exp_ifd = rv;
                end
                drop = 0;
            end
            if (e_if) begin
                open = 1; own_ls = 0; phase = 1; c_addr = ifa; c_w = 0; c_wd = '0; c_m = '0;
                ifp = 0; streak = 0;
            end else if (e_ls) begin
                open = 1; own_ls = 1; phase = 1; c_addr = lsa; c_w = lsw; c_wd = lswd; c_m = lsm;
                if (ifp && !if_flush) streak = (streak < MAXS) ? streak + 1 : MAXS;
                lsp = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();
        test_reset();
        test_store();
        test_starvation();
        test_flush_inflight();
        test_flush_idle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
